// File: rtl/posit_chk_pkg.sv
// Shared types and helpers for the posit result checker: run-state encoding,
// NaR pattern and unsigned bit-pattern distance.
package posit_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Widest posit word the helpers support; callers size-cast down to N.
   localparam int unsigned MAX_W = 64;

   function automatic logic [MAX_W-1:0] nar_of(input int unsigned n);
      logic [MAX_W-1:0] one;
      one = MAX_W'(1);
      return one << (n - 1);
   endfunction

   function automatic logic [MAX_W-1:0] abs_diff(input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/posit_sync_fifo.sv
// Synchronous FIFO holding golden posit words; pointers carry an extra wrap bit
// so full and empty are distinguished without a separate count.
module posit_sync_fifo #(
   parameter int unsigned W     = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic         push_en;
   logic         pop_en;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         if (pop_en)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   // NOTE: state flops take <= so every flop samples pre-edge values; = here would race.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push_en && !clr) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/posit_result_checker.sv
// Streaming checker comparing FMA posit results against a buffered golden
// stream, with on-board error statistics for emulation runs.
module posit_result_checker
   import posit_chk_pkg::*;
#(
   parameter int unsigned N     = 32,
   parameter int unsigned ES    = 2,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_vectors,
   input  logic [N-1:0]     tol,
   input  logic             exp_valid,
   output logic             exp_ready,
   input  logic [N-1:0]     exp_data,
   input  logic             dut_valid,
   input  logic [N-1:0]     dut_data,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] vec_count,
   output logic [CNT_W-1:0] error_count,
   output logic [N-1:0]     max_diff,
   output logic [CNT_W-1:0] first_err_idx,
   output logic             first_err_valid,
   output logic             underrun,
   output logic             diff_valid,
   output logic [N-1:0]     diff_out
);

   localparam logic [N-1:0] NAR = N'(nar_of(N));

   if (ES > N - 2) begin : g_es_check
      $error("posit_result_checker: ES too large for N");
   end

   state_e           state_q, state_d;
   logic [CNT_W-1:0] num_q, num_d;
   logic [N-1:0]     tol_q, tol_d;
   logic [CNT_W-1:0] vec_q, vec_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic [N-1:0]     max_q, max_d;
   logic [CNT_W-1:0] fidx_q, fidx_d;
   logic             fval_q, fval_d;
   logic             under_q, under_d;
   logic             dvalid_q, dvalid_d;
   logic [N-1:0]     dout_q, dout_d;

   logic         fifo_clr;
   logic         fifo_full;
   logic         fifo_empty;
   logic [N-1:0] head;
   logic         cmp_en;
   logic         exp_nar;
   logic         dut_nar;
   logic [N-1:0] raw_diff;
   logic [N-1:0] cmp_diff;
   logic         cmp_err;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      return (x == '1) ? x : x + CNT_W'(1);
   endfunction

   assign busy      = (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);
   assign exp_ready = busy && !fifo_full;
   assign cmp_en    = busy && dut_valid && !fifo_empty;

   posit_sync_fifo #(.W(N), .DEPTH(DEPTH)) u_gold_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (fifo_clr),
      .push  (exp_valid && exp_ready),
      .wdata (exp_data),
      .pop   (cmp_en),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A lone NaR is an unconditional error and reports the largest distance.
   assign exp_nar  = (head == NAR);
   assign dut_nar  = (dut_data == NAR);
   assign raw_diff = N'(abs_diff(MAX_W'(head), MAX_W'(dut_data)));
   always_comb begin
      cmp_diff = raw_diff;
      cmp_err  = (raw_diff > tol_q);
      if (exp_nar != dut_nar) begin
         cmp_diff = '1;
         cmp_err  = 1'b1;
      end else if (exp_nar) begin
         cmp_diff = '0;
         cmp_err  = 1'b0;
      end
   end

   always_comb begin
      state_d  = state_q;
      num_d    = num_q;
      tol_d    = tol_q;
      vec_d    = vec_q;
      err_d    = err_q;
      max_d    = max_q;
      fidx_d   = fidx_q;
      fval_d   = fval_q;
      under_d  = under_q;
      dvalid_d = 1'b0;
      dout_d   = dout_q;
      fifo_clr = 1'b0;
      if (state_q == ST_RUN) begin
         if (cmp_en) begin
            dvalid_d = 1'b1;
            dout_d   = cmp_diff;
            vec_d    = sat_inc(vec_q);
            if (cmp_diff > max_q) max_d = cmp_diff;
            if (cmp_err) begin
               err_d = sat_inc(err_q);
               if (!fval_q) begin
                  fidx_d = vec_q;
                  fval_d = 1'b1;
               end
            end
         end
         if (dut_valid && fifo_empty) under_d = 1'b1;
         if (vec_d == num_q) state_d = ST_DONE;
      end else if (start) begin
         state_d  = ST_RUN;
         num_d    = num_vectors;
         tol_d    = tol;
         vec_d    = '0;
         err_d    = '0;
         max_d    = '0;
         fidx_d   = '0;
         fval_d   = 1'b0;
         under_d  = 1'b0;
         fifo_clr = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         num_q    <= '0;
         tol_q    <= '0;
         vec_q    <= '0;
         err_q    <= '0;
         max_q    <= '0;
         fidx_q   <= '0;
         fval_q   <= 1'b0;
         under_q  <= 1'b0;
         dvalid_q <= 1'b0;
         dout_q   <= '0;
      end else begin
         state_q  <= state_d;
         num_q    <= num_d;
         tol_q    <= tol_d;
         vec_q    <= vec_d;
         err_q    <= err_d;
         max_q    <= max_d;
         fidx_q   <= fidx_d;
         fval_q   <= fval_d;
         under_q  <= under_d;
         dvalid_q <= dvalid_d;
         dout_q   <= dout_d;
      end
   end

   assign vec_count       = vec_q;
   assign error_count     = err_q;
   assign max_diff        = max_q;
   assign first_err_idx   = fidx_q;
   assign first_err_valid = fval_q;
   assign underrun        = under_q;
   assign diff_valid      = dvalid_q;
   assign diff_out        = dout_q;

endmodule

// File: tb/tb_posit_result_checker.sv
// Scoreboard bench for posit_result_checker: golden words are modelled in a
// queue, expected diffs are queued when DUT words are driven and checked on diff_valid.
module tb_posit_result_checker;

   localparam int unsigned N     = 32;
   localparam int unsigned ES    = 2;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned CNT_W = 32;
   localparam logic [N-1:0] NAR  = 32'h8000_0000;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] num_vectors = '0;
   logic [N-1:0]     tol = '0;
   logic             exp_valid = 1'b0;
   logic             exp_ready;
   logic [N-1:0]     exp_data = '0;
   logic             dut_valid = 1'b0;
   logic [N-1:0]     dut_data = '0;
   logic             busy, done;
   logic [CNT_W-1:0] vec_count, error_count, first_err_idx;
   logic [N-1:0]     max_diff, diff_out;
   logic             first_err_valid, underrun, diff_valid;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   logic [N-1:0] gold_q [$];
   logic [N-1:0] sb_q   [$];

   always #5 clk = ~clk;

   posit_result_checker #(.N(N), .ES(ES), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .num_vectors     (num_vectors),
      .tol             (tol),
      .exp_valid       (exp_valid),
      .exp_ready       (exp_ready),
      .exp_data        (exp_data),
      .dut_valid       (dut_valid),
      .dut_data        (dut_data),
      .busy            (busy),
      .done            (done),
      .vec_count       (vec_count),
      .error_count     (error_count),
      .max_diff        (max_diff),
      .first_err_idx   (first_err_idx),
      .first_err_valid (first_err_valid),
      .underrun        (underrun),
      .diff_valid      (diff_valid),
      .diff_out        (diff_out)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [N-1:0] model_diff(input logic [N-1:0] g, input logic [N-1:0] d);
      if ((g == NAR) != (d == NAR)) return '1;
      if (g == NAR) return '0;
      if (g > d) return g - d;
      return d - g;
   endfunction

   always @(negedge clk) begin
      if (rst_n && diff_valid) begin
         if (sb_q.size() == 0) check("unexpected_diff_valid", 1, 0);
         else check("diff_out", diff_out, sb_q.pop_front());
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [CNT_W-1:0] n, input logic [N-1:0] t);
      gold_q.delete();
      start = 1'b1;
      num_vectors = n;
      tol = t;
      tick();
      start = 1'b0;
   endtask

   task automatic push_gold(input logic [N-1:0] w);
      int unsigned waited = 0;
      while (!exp_ready && waited < 20) begin
         tick();
         waited++;
      end
      if (!exp_ready) begin
         check("exp_ready_timeout", 0, 1);
      end else begin
         exp_valid = 1'b1;
         exp_data = w;
         tick();
         exp_valid = 1'b0;
         gold_q.push_back(w);
      end
   endtask

   task automatic dut_send(input logic [N-1:0] d);
      if (gold_q.size() != 0) sb_q.push_back(model_diff(gold_q.pop_front(), d));
      dut_valid = 1'b1;
      dut_data = d;
      tick();
      dut_valid = 1'b0;
   endtask

   task automatic drain();
      @(negedge clk);
      #1;
      check("scoreboard_drained", sb_q.size(), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_exp_ready"}, exp_ready, 0);
      check({tag, "_vec_count"}, vec_count, 0);
      check({tag, "_error_count"}, error_count, 0);
      check({tag, "_max_diff"}, max_diff, 0);
      check({tag, "_first_err"}, {first_err_valid, first_err_idx}, 0);
      check({tag, "_underrun"}, underrun, 0);
      check({tag, "_diff"}, {diff_valid, diff_out}, 0);
   endtask

   initial begin
      logic [N-1:0] g4 [4];
      g4 = '{32'h4000_0000, 32'h4800_0000, 32'h3800_0000, 32'h0000_0000};

      #12;
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // Identical stream: clean run, done on the fourth comparison.
      start_run(4, 0);
      check("run1_busy", busy, 1);
      foreach (g4[i]) push_gold(g4[i]);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) check("run1_done_before_last", done, 0);
         dut_send(g4[i]);
      end
      check("run1_done", done, 1);
      check("run1_busy_low", busy, 0);
      check("run1_vec_count", vec_count, 4);
      check("run1_error_count", error_count, 0);
      check("run1_max_diff", max_diff, 0);
      drain();

      // One-LSB error on vector 1.
      start_run(3, 0);
      check("run2_cleared_vec", vec_count, 0);
      for (int i = 0; i < 3; i++) push_gold(32'h4000_0000);
      dut_send(32'h4000_0000);
      dut_send(32'h4000_0001);
      dut_send(32'h4000_0000);
      check("run2_error_count", error_count, 1);
      check("run2_first_err_idx", first_err_idx, 1);
      check("run2_first_err_valid", first_err_valid, 1);
      check("run2_max_diff", max_diff, 1);
      check("run2_done", done, 1);
      drain();

      // Tolerance 2: diffs 1, 2, 3 in both directions.
      start_run(3, 2);
      for (int i = 0; i < 3; i++) push_gold(32'h4000_0010);
      dut_send(32'h4000_0011);
      dut_send(32'h4000_000E);
      dut_send(32'h4000_0013);
      check("run3_error_count", error_count, 1);
      check("run3_first_err_idx", first_err_idx, 2);
      check("run3_max_diff", max_diff, 3);
      drain();

      // NaR handling.
      start_run(2, 0);
      push_gold(NAR);
      push_gold(NAR);
      dut_send(NAR);
      check("nar_both_no_error", error_count, 0);
      dut_send(32'h4000_0000);
      check("nar_one_error", error_count, 1);
      check("nar_first_idx", first_err_idx, 1);
      check("nar_max_diff", max_diff, 32'hFFFF_FFFF);
      drain();

      // Fill the FIFO, offer a ninth word, ignore start in RUN.
      start_run(5, 0);
      for (int i = 0; i < DEPTH; i++) push_gold(32'h4000_0000 + 32'(i));
      check("fifo_full_ready_low", exp_ready, 0);
      exp_valid = 1'b1;
      exp_data = 32'h7777_7777;
      tick();
      exp_valid = 1'b0;
      check("fifo_full_still_low", exp_ready, 0);
      start = 1'b1;
      num_vectors = 1;
      tick();
      start = 1'b0;
      check("start_in_run_ignored_busy", busy, 1);
      check("start_in_run_fifo_kept", exp_ready, 0);
      for (int i = 0; i < 5; i++) dut_send(32'h4000_0000 + 32'(i));
      check("fill_run_vec_count", vec_count, 5);
      check("fill_run_done", done, 1);
      check("fill_run_errors", error_count, 0);
      drain();

      // Fresh run clears leftovers: DUT word with empty FIFO is an underrun.
      start_run(2, 0);
      dut_send(32'h4000_0000);
      check("underrun_flag", underrun, 1);
      check("underrun_vec_count", vec_count, 0);
      check("underrun_busy", busy, 1);
      drain();

      // Asynchronous reset mid-run after two comparisons.
      start_run(4, 0);
      for (int i = 0; i < 4; i++) push_gold(32'h3000_0000);
      dut_send(32'h3000_0000);
      dut_send(32'h3000_0004);
      check("midrun_vec_count", vec_count, 2);
      drain();
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      gold_q.delete();
      sb_q.delete();
      #2;
      rst_n = 1'b1;
      tick();

      start_run(0, 0);
      check("zero_run_busy", busy, 1);
      check("zero_run_done_early", done, 0);
      tick();
      check("zero_run_done", done, 1);
      check("zero_run_vec_count", vec_count, 0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
